logic_gate_pipe: RTL and testbench
==================================

Name: logic_gate_pipe

Overview:
- Parametrised successor to the single-bit 2-input AND gate: a WIDTH-bit bitwise two-operand logic unit with run-time operation select.
- Registered output with valid/ready handshake, a 2-entry skid buffer and a completed-transfer counter.
- Sits between a stimulus/control source and any downstream consumer. It is the reusable gate primitive for later lab blocks.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the transfer counter (wraps modulo 2^CNT_W).

Ports:
- sys_clk  in  1  system clock; all state changes on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set A/B/op is valid.
- in_ready  out  1  block can accept an operand set; registered.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- op  in  3  operation select, sampled with A/B.
- out_valid  out  1  Y/y_all/y_any valid.
- out_ready  in  1  consumer accepts the result.
- Y  out  WIDTH  bitwise result.
- y_all  out  1  reduction AND of Y.
- y_any  out  1  reduction OR of Y.
- xfer_cnt  out  CNT_W  number of completed output transfers.

Behaviour:
- One clock domain (sys_clk). Reset is asynchronous, active-high (sys_rst).
- Reset values:
  - in_ready=1, out_valid=0, Y=0, y_all=0, y_any=0, xfer_cnt=0.
  - Skid buffer empty.
  - Reset asserted mid-transfer discards all held results; no partial output.
- op encoding (constants in package):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 PASS A.
- Result computation:
  - Computed combinationally from the sampled inputs and captured into a register on input accept.
  - y_all and y_any are computed from the same result and registered alongside Y.
  - Y, y_all, y_any are only meaningful while out_valid=1.
- Handshakes:
  - Input accept occurs on a cycle where in_valid & in_ready.
  - Output transfer occurs on a cycle where out_valid & out_ready.
  - A/B/op are not required to be stable once accepted.
- Latency: result appears at out_valid the cycle after accept (1 cycle) when the output register is empty or draining.
- Throughput: one result per cycle while out_ready stays high.
- Skid buffer (2 entries: output register + skid register):
  - Accept with the output register full and out_ready=0: the new result goes to the skid register, and in_ready drops to 0 on the next cycle.
  - in_ready = skid register empty (registered, no combinational path from out_ready).
  - Output transfer with the skid full: the skid content moves to the output register in the same edge, and in_ready returns to 1 on the next cycle.
  - Accept and output transfer in the same cycle: results stay ordered; no loss, no duplication.
  - Order is strictly FIFO.
- out_valid and Y must not change while out_valid=1 and out_ready=0 (stall hold).
- xfer_cnt:
  - +1 on each output transfer; wraps from 2^CNT_W-1 to 0.
  - Not incremented on input accept.

Decomposition:
- Package logic_gate_pkg:
  - op localparams OP_AND..OP_PASS.
  - Op width constant OP_W=3.
- Sub-module logic_gate_core: purely combinational (A, B, op -> Y).
  - Instantiated once.
  - Reused later by multi-channel variants.
- Top holds the skid/handshake control and the counter.

Test Plan (WIDTH=8, CNT_W=4):
- Release reset; check out_valid=0, in_ready=1, xfer_cnt=0. Send A=8'hF0, B=8'h3C, op=0 with out_ready=1 -> next cycle Y=8'h30, y_all=0, y_any=1, then xfer_cnt=1.
- Sweep op 0..7 with A=8'hAA, B=8'hCC, out_ready=1 -> Y = 88, EE, 66, 77, 11, 99, 55, AA in consecutive cycles.
- Hold out_ready=0 and send 3 back-to-back ops -> two accepted; in_ready=0 from the third cycle; Y stays constant. Raise out_ready -> both results delivered in order, then in_ready=1.
- Stream 20 results with out_ready toggling 1/0 each cycle -> every result is received exactly once and in order; xfer_cnt=20 mod 16 = 4.
- Assert sys_rst asynchronously (mid-cycle) while the skid is full -> out_valid=0 and xfer_cnt=0 immediately, with no sys_clk edge required. After release no stale results appear and in_ready=1.
- A=8'hFF, B=8'hFF, op=0 -> Y=FF, y_all=1. Then op=4 (NOR) -> Y=00, y_all=0, y_any=0.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Purpose: shared constants for the logic gate primitive (op encoding, op width).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package logic_gate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_core.sv
// Purpose: WIDTH-bit bitwise two-operand logic function selected by op.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; no state and no handshake.
// Ports: a, b (operands), op (function select), y (result).
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Purpose: registered logic unit with valid/ready in/out, 2-entry skid and transfer counter.
// Latency: 1 cycle from input accept to out_valid when the output register is empty or draining.
// Backpressure: in_ready = skid register empty (registered); drops after a stalled second accept.
// Ports: sys_clk/sys_rst (clock, async active-high reset); in_valid/in_ready with A, B, op;
//        out_valid/out_ready with Y, y_all, y_any; xfer_cnt counts completed output transfers.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             y_all,
  output logic             y_any,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             all;
    logic             any;
  } res_t;

  logic [WIDTH-1:0] core_y;
  res_t             new_res;

  logic             out_vld_q,  out_vld_d;
  res_t             out_res_q,  out_res_d;
  logic             skid_vld_q, skid_vld_d;
  res_t             skid_res_q, skid_res_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic acc;
  logic xfer;

  logic_gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (A),
    .b  (B),
    .op (op),
    .y  (core_y)
  );

  always_comb begin
    new_res.y   = core_y;
    new_res.all = &core_y;
    new_res.any = |core_y;
  end

  assign in_ready = ~skid_vld_q;
  assign acc      = in_valid & in_ready;
  assign xfer     = out_vld_q & out_ready;

  // Skid is only ever occupied while the output register is occupied, and
  // no accept can happen while the skid is full, so the cases below cover
  // every reachable combination.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_res_d  = out_res_q;
    skid_vld_d = skid_vld_q;
    skid_res_d = skid_res_q;
    cnt_d      = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (skid_vld_q) begin
        out_res_d  = skid_res_q;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        out_res_d = new_res;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (acc) begin
      if (out_vld_q) begin
        skid_res_d = new_res;
        skid_vld_d = 1'b1;
      end else begin
        out_res_d = new_res;
        out_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_vld_q  <= 1'b0;
      out_res_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_res_q <= '0;
      cnt_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_res_q  <= out_res_d;
      skid_vld_q <= skid_vld_d;
      skid_res_q <= skid_res_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = out_vld_q;
  assign Y         = out_res_q.y;
  assign y_all     = out_res_q.all;
  assign y_any     = out_res_q.any;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Purpose: self-checking bench for logic_gate_pipe against a queue-based reference model.
// Latency: model result visible one cycle after a modelled accept.
// Backpressure: model holds up to two results; in_ready modelled as fewer than two held.
module tb_logic_gate_pipe;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Y;
  logic       y_all;
  logic       y_any;
  logic [3:0] xfer_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: results in flight ({y, all, any}) and transfer count.
  logic [9:0] exp_q[$];
  int         cnt = 0;
  int         delivered = 0;

  always #5 sys_clk = ~sys_clk;

  logic_gate_pipe #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .y_all     (y_all),
    .y_any     (y_any),
    .xfer_cnt  (xfer_cnt)
  );

  // Per-bit truth table indexed by {a_bit, b_bit}.
  function automatic logic [9:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] o);
    logic [3:0] tt;
    logic [7:0] y;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) y[i] = tt[{a[i], b[i]}];
    return {y, (y == 8'hFF), (y != 8'h00)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle: present inputs, then advance the model across the rising edge.
  task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] o, input logic ordy);
    bit acc, xf;
    logic [9:0] r;
    @(negedge sys_clk);
    #1;
    in_valid  = iv;
    A         = a;
    B         = b;
    op        = o;
    out_ready = ordy;
    acc = iv && (exp_q.size() < 2);
    xf  = (exp_q.size() > 0) && ordy;
    r   = ref_res(a, b, o);
    @(posedge sys_clk);
    #1;
    if (xf) begin
      void'(exp_q.pop_front());
      cnt = (cnt + 1) % 16;
      delivered++;
    end
    if (acc) exp_q.push_back(r);
  endtask

  // Compare process: DUT against model on every cycle outside reset.
  always @(negedge sys_clk) begin
    if (chk_en && !sys_rst) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      chk("xfer_cnt", {28'd0, xfer_cnt}, cnt);
      if (exp_q.size() > 0) chk("result", {22'd0, Y, y_all, y_any}, {22'd0, exp_q[0]});
    end
  end

  logic [7:0] sweep [8];
  int         accepted;
  int         guard;

  initial begin
    sweep = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'h55, 8'hAA};

    // Reset state.
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_xfer_cnt", {28'd0, xfer_cnt}, 0);
    chk("rst_Y", {24'd0, Y}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    // First transaction.
    step(1, 8'hF0, 8'h3C, 3'd0, 1);
    chk("first_Y", {24'd0, Y}, 8'h30);
    chk("first_all", {31'd0, y_all}, 0);
    chk("first_any", {31'd0, y_any}, 1);
    chk("first_valid", {31'd0, out_valid}, 1);
    step(0, 8'h00, 8'h00, 3'd0, 1);
    chk("first_cnt", {28'd0, xfer_cnt}, 1);

    // Op sweep; literals also pin the model.
    for (int i = 0; i < 8; i++) begin
      step(1, 8'hAA, 8'hCC, 3'(i), 1);
      chk($sformatf("sweep_Y_op%0d", i), {24'd0, Y}, {24'd0, sweep[i]});
      chk($sformatf("model_op%0d", i), {24'd0, ref_res(8'hAA, 8'hCC, 3'(i)) >> 2},
          {24'd0, sweep[i]});
    end
    step(0, 8'h00, 8'h00, 3'd0, 1);

    // Stall: three back-to-back offers with out_ready low.
    step(1, 8'h0F, 8'h33, 3'd0, 0);
    chk("stall_Y1", {24'd0, Y}, 8'h03);
    step(1, 8'h0F, 8'h33, 3'd1, 0);
    chk("stall_Y2", {24'd0, Y}, 8'h03);
    chk("stall_rdy2", {31'd0, in_ready}, 0);
    step(1, 8'h0F, 8'h33, 3'd2, 0);
    chk("stall_Y3", {24'd0, Y}, 8'h03);
    chk("stall_rdy3", {31'd0, in_ready}, 0);
    step(0, 8'h00, 8'h00, 3'd0, 1);
    chk("drain_Y", {24'd0, Y}, 8'h3F);
    chk("drain_rdy", {31'd0, in_ready}, 1);
    step(0, 8'h00, 8'h00, 3'd0, 1);
    chk("drain_empty", {31'd0, out_valid}, 0);

    // Async reset with the skid full.
    step(1, 8'h12, 8'h34, 3'd1, 0);
    step(1, 8'h56, 8'h78, 3'd2, 0);
    chk("skid_full", {31'd0, in_ready}, 0);
    #2;
    sys_rst = 1'b1;
    exp_q.delete();
    cnt = 0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_xfer_cnt", {28'd0, xfer_cnt}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b0;
    step(0, 8'h00, 8'h00, 3'd0, 1);
    step(0, 8'h00, 8'h00, 3'd0, 1);
    chk("post_rst_valid", {31'd0, out_valid}, 0);

    // Stream 20 results with out_ready toggling.
    accepted = 0;
    delivered = 0;
    guard = 0;
    while (accepted < 20 && guard < 200) begin
      logic [7:0] a, b;
      logic [2:0] o;
      bit rdy_model;
      a = 8'($urandom);
      b = 8'($urandom);
      o = 3'($urandom_range(0, 7));
      rdy_model = (exp_q.size() < 2);
      step(1, a, b, o, guard[0]);
      if (rdy_model) accepted++;
      guard++;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      step(0, 8'h00, 8'h00, 3'd0, 1);
      guard++;
    end
    chk("stream_delivered", delivered, 20);
    chk("stream_cnt", {28'd0, xfer_cnt}, 4);

    // All-ones then NOR.
    step(1, 8'hFF, 8'hFF, 3'd0, 1);
    chk("ff_Y", {24'd0, Y}, 8'hFF);
    chk("ff_all", {31'd0, y_all}, 1);
    step(1, 8'hFF, 8'hFF, 3'd4, 1);
    chk("nor_Y", {24'd0, Y}, 8'h00);
    chk("nor_all", {31'd0, y_all}, 0);
    chk("nor_any", {31'd0, y_any}, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 3'd0, 1);
    chk("final_empty", {31'd0, out_valid}, 0);

    @(negedge sys_clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
